// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the SCCPU integer ALU:
//     - operation-select width and encodings (ALU_NOP .. ALU_SLTU, ALU_RSV)
//     - default datapath width
//     - small decode helpers used by the top level
// -----------------------------------------------------------------------------
package alu_pkg;

  // Default operand/result width. All arithmetic is modulo 2**ALU_WIDTH.
  localparam int ALU_WIDTH = 32;

  // Width of the ALUOp select field.
  localparam int ALU_OP_W = 3;

  // Operation encodings.
  localparam logic [ALU_OP_W-1:0] ALU_NOP  = 3'b000; // C = A
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b001; // C = A + B
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b010; // C = A - B
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b011; // C = A & B
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b100; // C = A | B
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 3'b101; // signed   A < B
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 3'b110; // unsigned A < B
  localparam logic [ALU_OP_W-1:0] ALU_RSV  = 3'b111; // reserved, C = 0

  // The shared adder runs in subtract mode for SUB and for both compares;
  // only ADD needs a true addition.
  function automatic logic op_uses_sub(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

  // ADD and SUB are the only ops that expose the adder's Carry/Overflow.
  function automatic logic op_is_arith(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
//   WIDTH-bit adder/subtractor shared by ADD, SUB, SLT and SLTU.
//   Subtraction is A + ~B + 1 (B inverted, carry-in = sub).
//
// Ports
//   a        in  WIDTH  first operand
//   b        in  WIDTH  second operand
//   sub      in  1      0: a + b, 1: a - b
//   sum      out WIDTH  result modulo 2**WIDTH
//   carry    out 1      carry-out; in subtract mode this is not-borrow (a >= b)
//   overflow out 1      two's-complement signed overflow of the operation
// -----------------------------------------------------------------------------
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;

  // One extra bit of headroom captures the carry-out directly.
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH];

  // Signed overflow: both addends share a sign and the sum's sign differs.
  // Using b_eff makes this cover subtraction too (A + ~B + 1).
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1]);

endmodule : alu_addsub

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   32-bit integer ALU for the single-cycle CPU datapath. The result C and
//   the flags are combinational so the datapath can use them in the same
//   cycle; a registered copy of C/Zero plus a valid strobe is provided for
//   pipelined or debug consumers.
//
// Ports
//   clk      in  1      rising edge updates C_q, Zero_q, valid_q
//   rstn     in  1      asynchronous active-low reset of the registered copy
//   A        in  WIDTH  operand A (rs1)
//   B        in  WIDTH  operand B (rs2 or immediate)
//   ALUOp    in  3      operation select (see alu_pkg)
//   C        out WIDTH  combinational result
//   Zero     out 1      combinational, C == 0
//   Overflow out 1      combinational signed overflow, ADD/SUB only
//   Carry    out 1      combinational carry (ADD) / not-borrow (SUB)
//   C_q      out WIDTH  registered C
//   Zero_q   out 1      registered Zero
//   valid_q  out 1      1 from the first rising edge after reset release
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] ALUOp,
  output logic [WIDTH-1:0]    C,
  output logic                Zero,
  output logic                Overflow,
  output logic                Carry,
  output logic [WIDTH-1:0]    C_q,
  output logic                Zero_q,
  output logic                valid_q
);

  // ---------------------------------------------------------------------------
  // Shared adder
  // ---------------------------------------------------------------------------
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             as_carry;
  logic             as_ovf;
  logic             lt_signed;
  logic             lt_unsigned;

  assign sub = op_uses_sub(ALUOp);

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a        (A),
    .b        (B),
    .sub      (sub),
    .sum      (sum),
    .carry    (as_carry),
    .overflow (as_ovf)
  );

  // Signed less-than is the sign of A - B corrected by overflow, so it stays
  // right when the subtraction wraps (e.g. 0x7FFFFFFF vs 0x80000000).
  assign lt_signed   = sum[WIDTH-1] ^ as_ovf;
  // Unsigned less-than is a borrow, i.e. the inverted not-borrow carry.
  assign lt_unsigned = ~as_carry;

  // ---------------------------------------------------------------------------
  // Result mux and flags
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that keeps this block purely combinational (no latches) and
    // gives the reserved op a defined all-zero result.
    C        = '0;
    Overflow = 1'b0;
    Carry    = 1'b0;
    case (ALUOp)
      ALU_NOP:  C = A;
      ALU_ADD,
      ALU_SUB:  C = sum;
      ALU_AND:  C = A & B;
      ALU_OR:   C = A | B;
      ALU_SLT:  C = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU: C = {{(WIDTH-1){1'b0}}, lt_unsigned};
      default:  C = '0;
    endcase
    if (op_is_arith(ALUOp)) begin
      Overflow = as_ovf;
      Carry    = as_carry;
    end
  end

  // Zero follows the final C for every op, including NOP and the compares.
  assign Zero = (C == '0);

  // ---------------------------------------------------------------------------
  // Registered copy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      C_q     <= '0;
      Zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking ones would create order-dependent races.
      C_q     <= C;
      Zero_q  <= Zero;
      valid_q <= 1'b1;
    end
  end

endmodule : alu

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//   Self-checking bench for alu. Expected results are pushed to scoreboard
//   queues when stimulus is driven and popped when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_alu;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] c;
    logic         z;
    logic         v;
    logic         cy;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    exp_t         e;
  } vec_t;

  logic                clk;
  logic                rstn;
  logic [W-1:0]        a;
  logic [W-1:0]        b;
  logic [ALU_OP_W-1:0] op;
  logic [W-1:0]        c;
  logic                zero;
  logic                ovf;
  logic                carry;
  logic [W-1:0]        c_q;
  logic                zero_q;
  logic                valid_q;

  int total = 0;
  int bad   = 0;

  exp_t comb_q[$];
  exp_t reg_q[$];

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .A        (a),
    .B        (b),
    .ALUOp    (op),
    .C        (c),
    .Zero     (zero),
    .Overflow (ovf),
    .Carry    (carry),
    .C_q      (c_q),
    .Zero_q   (zero_q),
    .valid_q  (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model built on 64-bit signed/unsigned arithmetic.
  localparam longint MAX_S = 64'sh7FFF_FFFF;
  localparam longint MIN_S = -64'sh8000_0000;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [2:0] mop);
    exp_t   r;
    longint sa;
    longint sb;
    longint s;
    longint ua;
    longint ub;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = longint'({32'd0, ma});
    ub = longint'({32'd0, mb});
    r.c = '0; r.v = 1'b0; r.cy = 1'b0;
    case (mop)
      3'd0: r.c = ma;
      3'd1: begin
        s    = ua + ub;
        r.c  = s[W-1:0];
        r.cy = (s > 64'sh FFFF_FFFF);
        s    = sa + sb;
        r.v  = (s > MAX_S) || (s < MIN_S);
      end
      3'd2: begin
        s    = ua - ub;
        r.c  = s[W-1:0];
        r.cy = (ua >= ub);
        s    = sa - sb;
        r.v  = (s > MAX_S) || (s < MIN_S);
      end
      3'd3: r.c = ma & mb;
      3'd4: r.c = ma | mb;
      3'd5: r.c = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r.c = (ua < ub) ? 32'd1 : 32'd0;
      default: r.c = '0;
    endcase
    r.z = (r.c == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [5];
    corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                32'h7FFF_FFFF, 32'h8000_0000};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic check_comb(input string tag);
    exp_t e;
    if (comb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = comb_q.pop_front();
    check({tag, "_C"},        c,            e.c);
    check({tag, "_Zero"},     {31'd0, zero},  {31'd0, e.z});
    check({tag, "_Overflow"}, {31'd0, ovf},   {31'd0, e.v});
    check({tag, "_Carry"},    {31'd0, carry}, {31'd0, e.cy});
  endtask

  task automatic check_reg(input string tag);
    exp_t e;
    if (reg_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = reg_q.pop_front();
    check({tag, "_C_q"},     c_q,              e.c);
    check({tag, "_Zero_q"},  {31'd0, zero_q},  {31'd0, e.z});
    check({tag, "_valid_q"}, {31'd0, valid_q}, 32'd1);
  endtask

  // Directed vectors with hand-derived expectations {C, Zero, Overflow, Carry}.
  vec_t dir [15];
  initial begin
    dir = '{
      '{32'h0000_00A0, 32'h0000_000A, 3'b001, '{32'h0000_00AA, 1'b0, 1'b0, 1'b0}},
      '{32'h0000_00A0, 32'h0000_000A, 3'b010, '{32'h0000_0096, 1'b0, 1'b0, 1'b1}},
      '{32'h0000_00A0, 32'h0000_00A0, 3'b010, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}},
      '{32'hFFFF_FFFF, 32'h0000_0001, 3'b101, '{32'h0000_0001, 1'b0, 1'b0, 1'b0}},
      '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, '{32'h0000_0000, 1'b1, 1'b0, 1'b0}},
      '{32'hFFFF_FFFF, 32'h0000_0001, 3'b001, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}},
      '{32'h7FFF_FFFF, 32'h0000_0001, 3'b001, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}},
      '{32'h8000_0000, 32'h0000_0001, 3'b010, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1}},
      '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, '{32'h00F0_00F0, 1'b0, 1'b0, 1'b0}},
      '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, '{32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0}},
      '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, '{32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0}},
      '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b111, '{32'h0000_0000, 1'b1, 1'b0, 1'b0}},
      // Signed compare where A - B overflows.
      '{32'h7FFF_FFFF, 32'h8000_0000, 3'b101, '{32'h0000_0000, 1'b1, 1'b0, 1'b0}},
      '{32'h8000_0000, 32'h7FFF_FFFF, 3'b101, '{32'h0000_0001, 1'b0, 1'b0, 1'b0}},
      '{32'h0000_0000, 32'h0000_0000, 3'b000, '{32'h0000_0000, 1'b1, 1'b0, 1'b0}}
    };
  end

  // Watchdog: the run must always reach its summary.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rstn = 1'b0;
    a    = '0;
    b    = '0;
    op   = ALU_NOP;

    // Registered copy held clear while in reset, across clock edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst_C_q",     c_q,              32'd0);
    check("rst_Zero_q",  {31'd0, zero_q},  32'd0);
    check("rst_valid_q", {31'd0, valid_q}, 32'd0);

    // Combinational path, still in reset to show independence from rstn.
    foreach (dir[i]) begin
      a  = dir[i].a;
      b  = dir[i].b;
      op = dir[i].op;
      comb_q.push_back(dir[i].e);
      #1;
      check_comb($sformatf("dir%0d", i));
    end

    // Release reset and load ADD 0xA0 + 0x0A on the first edge.
    @(negedge clk);
    rstn = 1'b1;
    a    = 32'h0000_00A0;
    b    = 32'h0000_000A;
    op   = ALU_ADD;
    e    = model(a, b, op);
    reg_q.push_back(e);
    @(posedge clk);
    #1;
    check("first_C_q_is_AA", c_q, 32'h0000_00AA);
    check_reg("first");

    // Randomised stream: comb outputs checked after settling, register one
    // edge later.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a  = pick_operand();
      b  = (i % 7 == 0) ? a : pick_operand();
      op = 3'($urandom_range(0, 7));
      e  = model(a, b, op);
      comb_q.push_back(e);
      reg_q.push_back(e);
      #1;
      check_comb($sformatf("rnd%0d", i));
      @(posedge clk);
      #1;
      check_reg($sformatf("rnd%0d", i));
    end

    // Mid-cycle asynchronous reset: load a non-zero value, then drop rstn
    // between edges and expect an immediate clear.
    @(negedge clk);
    a  = 32'h0000_00A0;
    b  = 32'h0000_000A;
    op = ALU_ADD;
    @(posedge clk);
    #1;
    check("pre_async_C_q", c_q, 32'h0000_00AA);
    #2;
    rstn = 1'b0;
    #1;
    check("async_C_q",     c_q,              32'd0);
    check("async_Zero_q",  {31'd0, zero_q},  32'd0);
    check("async_valid_q", {31'd0, valid_q}, 32'd0);
    check("async_comb_C",  c,                32'h0000_00AA);

    check("sb_comb_left", 32'(comb_q.size()), 32'd0);
    check("sb_reg_left",  32'(reg_q.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu
